// File: rtl/safety_tcm_rd_slave_if.sv
// safety_tcm_rd_slave_if: AXI4 read-only bundle (AR + R channels)
// master drives AR and rready; slave drives arready and R beats
interface safety_tcm_rd_slave_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr,
    output arlen,
    output arsize,
    output arburst,
    output arvalid,
    output rready,
    input  arready,
    input  rdata,
    input  rresp,
    input  rlast,
    input  rvalid
  );

  modport slave (
    input  araddr,
    input  arlen,
    input  arsize,
    input  arburst,
    input  arvalid,
    input  rready,
    output arready,
    output rdata,
    output rresp,
    output rlast,
    output rvalid
  );
endinterface

// File: rtl/safety_tcm_rd_slave.sv
// safety_tcm_rd_slave: AXI4 read-only slave serving a 64-bit TCM SRAM
// Ports: clk_i/rst_n_i (sync, active-low), axi (AR/R slave),
//   sram_req_o/sram_addr_o/sram_rdata_i (1-cycle read SRAM),
//   err_cnt_o (saturating count of non-OKAY beats returned)
module safety_tcm_rd_slave #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          DEPTH_WORDS   = 4096,
  parameter int          AR_FIFO_DEPTH = 2,
  localparam int         AW = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  safety_tcm_rd_slave_if.slave axi,
  output logic                 sram_req_o,
  output logic [AW-1:0]        sram_addr_o,
  input  logic [63:0]          sram_rdata_i,
  output logic [15:0]          err_cnt_o
);

  localparam int PW =
    (AR_FIFO_DEPTH > 1) ? $clog2(AR_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(AR_FIFO_DEPTH + 1);
  localparam logic [28:0] BASE_W = BASE_ADDR[31:3];
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

  typedef struct packed {
    logic [28:0] wa;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] resp;
    logic       last;
  } tag_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_t;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  // byte offset within a word is ignored
  logic unused_lo;
  assign unused_lo = ^axi.araddr[2:0];

  // ---------------- AR queue ----------------
  ar_t           fifo_q [AR_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          ar_push;
  logic          ar_pop;
  logic          fifo_ne;
  ar_t           head;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(AR_FIFO_DEPTH - 1)) ?
      '0 : p + PW'(1);
  endfunction

  assign axi.arready = (cnt_q != CW'(AR_FIFO_DEPTH));
  assign ar_push     = axi.arvalid & axi.arready;
  assign fifo_ne     = (cnt_q != '0);
  assign head        = fifo_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (ar_push) begin
      fifo_q[wr_ptr_q] <= '{
        wa:    axi.araddr[31:3],
        len:   axi.arlen,
        size:  axi.arsize,
        burst: axi.arburst
      };
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (ar_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (ar_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(ar_push) - CW'(ar_pop);
    end
  end

  function automatic logic slv_chk(input ar_t a);
    logic bad_wrap;
    bad_wrap = (a.burst == 2'b10) &&
      !(a.len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return (a.size != 3'd3) | bad_wrap;
  endfunction

  // ---------------- burst engine ----------------
  state_t      state_q;
  state_t      state_d;
  logic [28:0] wa_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic [1:0]  burst_q;
  logic        slv_q;

  logic        idle;
  logic [28:0] cur_wa;
  logic [7:0]  cur_len;
  logic [7:0]  cur_beat;
  logic [1:0]  cur_burst;
  logic        cur_slv;
  logic        have_beat;
  logic        credit_ok;
  logic        issue;
  logic        is_last;
  logic        ld_head;
  logic        adv;
  logic [28:0] nwa;
  logic [28:0] mask;
  logic [28:0] woff;
  logic        in_rng;
  logic [1:0]  beat_resp;
  logic        r_hs;
  logic [1:0]  cred_q;

  // in IDLE the queue head is served directly so beat 0
  // leaves the same cycle it is popped
  assign idle      = (state_q == S_IDLE);
  assign cur_wa    = idle ? head.wa    : wa_q;
  assign cur_len   = idle ? head.len   : len_q;
  assign cur_burst = idle ? head.burst : burst_q;
  assign cur_slv   = idle ? slv_chk(head) : slv_q;
  assign cur_beat  = idle ? 8'd0 : beat_q;

  assign have_beat = !idle | fifo_ne;
  assign credit_ok = (cred_q != 2'd0) | r_hs;
  assign issue     = have_beat & credit_ok;
  assign is_last   = (cur_beat == cur_len);

  assign mask = {21'd0, cur_len};

  always_comb begin
    nwa = cur_wa + 29'd1;
    unique case (1'b1)
      (cur_burst == 2'b00): nwa = cur_wa;
      (cur_burst == 2'b10):
        nwa = (cur_wa & ~mask) |
              ((cur_wa + 29'd1) & mask);
      default: nwa = cur_wa + 29'd1;
    endcase
  end

  assign woff   = cur_wa - BASE_W;
  assign in_rng = (cur_wa >= BASE_W) &&
                  ({1'b0, woff} < DEPTH_W);

  always_comb begin
    beat_resp = 2'b00;
    unique case (1'b1)
      cur_slv: beat_resp = 2'b10;
      !in_rng: beat_resp = 2'b11;
      default: beat_resp = 2'b00;
    endcase
  end

  assign sram_req_o  = issue & (beat_resp == 2'b00);
  assign sram_addr_o = sram_req_o ? woff[AW-1:0] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fifo_ne)
          state_d = (issue && is_last) ?
            S_IDLE : S_ACTIVE;
      end
      S_ACTIVE: begin
        if (issue && is_last)
          state_d = fifo_ne ? S_ACTIVE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ar_pop  = 1'b0;
    ld_head = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ar_pop  = fifo_ne;
        ld_head = fifo_ne;
        adv     = issue;
      end
      S_ACTIVE: begin
        if (issue && is_last) begin
          ar_pop  = fifo_ne;
          ld_head = fifo_ne;
        end else begin
          adv = issue;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wa_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      slv_q   <= 1'b0;
    end else if (ld_head) begin
      wa_q    <= adv ? nwa : head.wa;
      len_q   <= head.len;
      burst_q <= head.burst;
      slv_q   <= slv_chk(head);
      beat_q  <= adv ? 8'd1 : 8'd0;
    end else if (adv) begin
      wa_q   <= nwa;
      beat_q <= beat_q + 8'd1;
    end
  end

  // ---------------- SRAM return stage ----------------
  tag_t p1_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      p1_q <= '0;
    end else begin
      p1_q <= '{
        vld:  issue,
        resp: beat_resp,
        last: is_last
      };
    end
  end

  // ---------------- R buffer + credits ----------------
  // credits + in-flight tag + buffered beats always sum to 2
  r_t         rbuf_q [2];
  logic       rb_wr_q;
  logic       rb_rd_q;
  logic [1:0] rb_cnt_q;
  r_t         rb_head;

  assign rb_head    = rbuf_q[rb_rd_q];
  assign axi.rvalid = (rb_cnt_q != 2'd0);
  assign axi.rdata  = axi.rvalid ? rb_head.data : '0;
  assign axi.rresp  = axi.rvalid ? rb_head.resp : '0;
  assign axi.rlast  = axi.rvalid & rb_head.last;
  assign r_hs       = axi.rvalid & axi.rready;

  always_ff @(posedge clk_i) begin
    if (p1_q.vld) begin
      rbuf_q[rb_wr_q] <= '{
        data: (p1_q.resp == 2'b00) ?
          sram_rdata_i : 64'd0,
        resp: p1_q.resp,
        last: p1_q.last
      };
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rb_wr_q  <= 1'b0;
      rb_rd_q  <= 1'b0;
      rb_cnt_q <= 2'd0;
      cred_q   <= 2'd2;
    end else begin
      if (p1_q.vld) rb_wr_q <= ~rb_wr_q;
      if (r_hs)     rb_rd_q <= ~rb_rd_q;
      rb_cnt_q <= rb_cnt_q + 2'(p1_q.vld) - 2'(r_hs);
      cred_q   <= cred_q - 2'(issue) + 2'(r_hs);
    end
  end

  // ---------------- error counter ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_cnt_o <= '0;
    end else if (r_hs && (axi.rresp != 2'b00) &&
                 (err_cnt_o != 16'hFFFF)) begin
      err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_safety_tcm_rd_slave.sv
// tb_safety_tcm_rd_slave: scoreboard bench for safety_tcm_rd_slave
// directed AR vectors; R beats checked by a decoupled monitor
`timescale 1ns/1ps
module tb_safety_tcm_rd_slave;
  localparam int AW = 12;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sram_req;
  logic [AW-1:0] sram_addr;
  logic [63:0]   sram_rdata;
  logic [15:0]   err_cnt;

  safety_tcm_rd_slave_if axi();

  safety_tcm_rd_slave #(
    .BASE_ADDR    (32'h0000_0000),
    .DEPTH_WORDS  (4096),
    .AR_FIFO_DEPTH(2)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .axi         (axi),
    .sram_req_o  (sram_req),
    .sram_addr_o (sram_addr),
    .sram_rdata_i(sram_rdata),
    .err_cnt_o   (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sval(input logic [11:0] w);
    return {16'hCAFE, 4'h0, w, 16'hBEEF, 4'h0, w};
  endfunction

  // SRAM model: data one cycle after req, junk otherwise
  always @(posedge clk)
    sram_rdata <= sram_req ? sval(sram_addr) : 64'hFFFF_FFFF_FFFF_FFFF;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    req_cnt = 0;
  int    hold_viol = 0;
  int    cred_viol = 0;
  int    beat_idx = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_ok(input logic [11:0] w, input logic last);
    exp_q.push_back({sval(w), 2'b00, last});
  endtask

  task automatic exp_err(input logic [1:0] r, input logic last);
    exp_q.push_back({64'd0, r, last});
  endtask

  task automatic monitor();
    beat_t got;
    beat_t prev;
    beat_t e;
    bit    stall = 1'b0;
    int    outst = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        outst = 0;
      end else begin
        got = {axi.rdata, axi.rresp, axi.rlast};
        if (stall && (!axi.rvalid || got != prev)) hold_viol++;
        if (sram_req) begin
          req_cnt++;
          outst++;
        end
        if (axi.rvalid && axi.rready) begin
          if (axi.rresp == 2'b00) outst--;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL r_unexpected: got data=%0h resp=%0d last=%0b, expected no beat",
                     got.data, got.resp, got.last);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_fail++;
              $display("FAIL r_beat%0d: got data=%0h resp=%0d last=%0b, expected data=%0h resp=%0d last=%0b",
                       beat_idx, got.data, got.resp, got.last,
                       e.data, e.resp, e.last);
            end
          end
          beat_idx++;
        end
        if (outst > 2) cred_viol++;
        stall = axi.rvalid && !axi.rready;
        prev  = got;
      end
    end
  endtask

  task automatic ar(input logic [31:0] a, input logic [7:0] l,
                    input logic [2:0] s, input logic [1:0] b);
    axi.araddr  = a;
    axi.arlen   = l;
    axi.arsize  = s;
    axi.arburst = b;
    axi.arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axi.arready) break;
    end
    if (!axi.arready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ar_timeout: got arready=0 expected 1");
    end
    @(posedge clk);
    #1 axi.arvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++)
      @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic lat_single();
    exp_ok(12'h020, 1'b1);
    ar(32'h0000_0100, 8'd0, 3'd3, 2'b01);
    @(negedge clk);
    chk("lat_req", 64'(sram_req), 64'd1);
    chk("lat_addr", 64'(sram_addr), 64'h20);
    @(negedge clk);
    chk("lat_rvalid_t2", 64'(axi.rvalid), 64'd0);
    @(negedge clk);
    chk("lat_rvalid_t3", 64'(axi.rvalid), 64'd1);
    chk("lat_rlast_t3", 64'(axi.rlast), 64'd1);
    drain();
  endtask

  initial begin
    int run;
    int rc0;
    axi.araddr  = '0;
    axi.arlen   = '0;
    axi.arsize  = '0;
    axi.arburst = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
    fork
      monitor();
    join_none

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 64'(axi.arready), 64'd1);
    chk("rst_rvalid", 64'(axi.rvalid), 64'd0);
    chk("rst_rlast", 64'(axi.rlast), 64'd0);
    chk("rst_rresp", 64'(axi.rresp), 64'd0);
    chk("rst_rdata", axi.rdata, 64'd0);
    chk("rst_sram_req", 64'(sram_req), 64'd0);
    chk("rst_sram_addr", 64'(sram_addr), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single read, latency
    lat_single();

    // two INCR len=7 bursts back to back
    for (int i = 0; i < 8; i++) exp_ok(12'(i), i == 7);
    for (int i = 0; i < 8; i++) exp_ok(12'h040 + 12'(i), i == 7);
    ar(32'h0000_0000, 8'd7, 3'd3, 2'b01);
    ar(32'h0000_0200, 8'd7, 3'd3, 2'b01);
    for (int i = 0; i < 20 && !axi.rvalid; i++) @(negedge clk);
    run = 0;
    for (int i = 0; i < 16; i++) begin
      if (axi.rvalid) run++;
      @(negedge clk);
    end
    chk("b2b_run", 64'(run), 64'd16);
    drain();

    // WRAP len=3 at word 3
    exp_ok(12'd3, 1'b0);
    exp_ok(12'd0, 1'b0);
    exp_ok(12'd1, 1'b0);
    exp_ok(12'd2, 1'b1);
    ar(32'h0000_0018, 8'd3, 3'd3, 2'b10);
    drain();

    // WRAP len=2: illegal length
    rc0 = req_cnt;
    for (int i = 0; i < 3; i++) exp_err(2'b10, i == 2);
    ar(32'h0000_0000, 8'd2, 3'd3, 2'b10);
    drain();
    chk("wrap_bad_no_req", 64'(req_cnt - rc0), 64'd0);
    chk("err_cnt_3", 64'(err_cnt), 64'd3);

    // INCR crossing the top of the window
    exp_ok(12'd4094, 1'b0);
    exp_ok(12'd4095, 1'b0);
    exp_err(2'b11, 1'b0);
    exp_err(2'b11, 1'b1);
    ar(32'h0000_7FF0, 8'd3, 3'd3, 2'b01);
    drain();

    // arsize=2
    exp_err(2'b10, 1'b0);
    exp_err(2'b10, 1'b1);
    ar(32'h0000_0000, 8'd1, 3'd2, 2'b01);
    drain();
    chk("err_cnt_7", 64'(err_cnt), 64'd7);

    // back-pressure on a len=15 burst
    for (int i = 0; i < 16; i++) exp_ok(12'h080 + 12'(i), i == 15);
    ar(32'h0000_0400, 8'd15, 3'd3, 2'b01);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1 axi.rready = 1'($urandom_range(0, 1));
    end
    axi.rready = 1'b1;
    drain();
    chk("hold_stable", 64'(hold_viol), 64'd0);
    chk("credit_bound", 64'(cred_viol), 64'd0);

    // reset during beat 5 of a len=15 burst
    for (int i = 0; i < 16; i++) exp_ok(12'(i), i == 15);
    ar(32'h0000_0000, 8'd15, 3'd3, 2'b01);
    for (int i = 0; i < 20 && !axi.rvalid; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_rvalid", 64'(axi.rvalid), 64'd0);
    chk("mid_rst_arready", 64'(axi.arready), 64'd1);
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    repeat (20) @(negedge clk);
    chk("mid_rst_no_beats", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    lat_single();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
